// File: rtl/fpu_ctrl_pkg.sv
// Shared encodings for the FPU operation controller: operation types, op codes,
// FSM states and the stb/busy transfer helper used on both FPU handshakes.
// Pure declarations; no logic of its own.
package fpu_ctrl_pkg;

    // Operation-type encodings; values above OPT_I are illegal instructions.
    localparam logic [1:0] OPT_R = 2'd0;
    localparam logic [1:0] OPT_I = 2'd1;

    // FPU op codes, passed through unchanged to the unit.
    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2,
        OP_DIV = 2'd3
    } op_code_e;

    // Controller FSM states.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LATCH  = 3'd1,
        S_ISSUE  = 3'd2,
        S_WAIT   = 3'd3,
        S_WRITE  = 3'd4,
        S_COMMIT = 3'd5
    } state_e;

    // A transfer happens on an edge where the strobe is high and busy is low.
    function automatic logic xfer(input logic stb, input logic busy);
        return stb & ~busy;
    endfunction

endpackage

// File: rtl/fpu_ctrl_watchdog.sv
// Timeout counter for the FPU handshake states; raises expired on the
// TIMEOUT_CYCLES-th consecutive cycle of run since the last clear.
// No backpressure; clear has priority over counting.
module fpu_ctrl_watchdog #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] count;

    assign expired = run && (count == CW'(TIMEOUT_CYCLES - 1));

    // Count cycles spent waiting; restart whenever a waiting state is entered.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (run && !expired) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/fpu_op_controller.sv
// Runs one FP ALU instruction: operand read, FPU strobe/busy handshake, write-back.
// Latency start->done is 5+N cycles for an FPU answering N cycles after accept.
// Holds unit_in_stb until accepted; optional watchdog via FPU_CTRL_TIMEOUT_EN.
module fpu_op_controller
    import fpu_ctrl_pkg::*;
#(
    parameter int WORD_SIZE              = 32,
    parameter int NUMBER_OF_REGISTERS    = 32,
    parameter int NUMBER_OF_PC_REGISTERS = 256,
    parameter int ZERO_REG_PROTECT       = 1,
    parameter int TIMEOUT_CYCLES         = 64,
    localparam int ADDR_WIDTH            = $clog2(NUMBER_OF_REGISTERS),
    localparam int PC_WIDTH              = $clog2(NUMBER_OF_PC_REGISTERS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            operation_type,
    input  logic [1:0]            op_code,
    input  logic [PC_WIDTH-1:0]   pc,
    input  logic [ADDR_WIDTH-1:0] source_1_address,
    input  logic [ADDR_WIDTH-1:0] source_2_address,
    input  logic [ADDR_WIDTH-1:0] destination_address,
    input  logic [WORD_SIZE-1:0]  source_immediate_value,
    output logic [ADDR_WIDTH-1:0] rs1,
    output logic [ADDR_WIDTH-1:0] rs2,
    output logic [ADDR_WIDTH-1:0] rd,
    input  logic [WORD_SIZE-1:0]  source_1_value,
    input  logic [WORD_SIZE-1:0]  source_2_value,
    output logic [WORD_SIZE-1:0]  destination_value,
    output logic                  write_enable,
    output logic [PC_WIDTH-1:0]   next_pc,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [WORD_SIZE-1:0]  unit_a,
    output logic [WORD_SIZE-1:0]  unit_b,
    output logic [1:0]            unit_op,
    output logic                  unit_in_stb,
    input  logic                  unit_in_busy,
    input  logic [WORD_SIZE-1:0]  unit_out,
    input  logic                  unit_out_stb,
    output logic                  unit_out_busy
);

    state_e                state, state_n;
    logic [PC_WIDTH-1:0]   pc_q, pc_q_n;
    logic [1:0]            op_type_q, op_type_q_n;
    logic [WORD_SIZE-1:0]  imm_q, imm_q_n;

    logic [ADDR_WIDTH-1:0] rs1_n, rs2_n, rd_n;
    logic [WORD_SIZE-1:0]  destination_value_n, unit_a_n, unit_b_n;
    logic [PC_WIDTH-1:0]   next_pc_n;
    logic [1:0]            unit_op_n;
    logic                  write_enable_n, busy_n, done_n, error_n;
    logic                  unit_in_stb_n, unit_out_busy_n;
    logic                  timeout;

`ifdef FPU_CTRL_TIMEOUT_EN
    logic wd_clear;

    // Restart the watchdog on every entry into ISSUE or WAIT.
    assign wd_clear = (state_n != state) && ((state_n == S_ISSUE) || (state_n == S_WAIT));

    fpu_ctrl_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clear  (wd_clear),
        .run    ((state == S_ISSUE) || (state == S_WAIT)),
        .expired(timeout)
    );
`else
    assign timeout = 1'b0;
`endif

    // Next-state and next-output logic; every register holds unless a state acts on it.
    always_comb begin
        state_n             = state;
        pc_q_n              = pc_q;
        op_type_q_n         = op_type_q;
        imm_q_n             = imm_q;
        rs1_n               = rs1;
        rs2_n               = rs2;
        rd_n                = rd;
        destination_value_n = destination_value;
        unit_a_n            = unit_a;
        unit_b_n            = unit_b;
        unit_op_n           = unit_op;
        next_pc_n           = next_pc;
        write_enable_n      = 1'b0;
        busy_n              = busy;
        done_n              = 1'b0;
        error_n             = error;
        unit_in_stb_n       = unit_in_stb;
        unit_out_busy_n     = unit_out_busy;

        case (state)
            S_IDLE: begin
                if (start) begin
                    pc_q_n      = pc;
                    op_type_q_n = operation_type;
                    imm_q_n     = source_immediate_value;
                    unit_op_n   = op_code;
                    rs1_n       = source_1_address;
                    rs2_n       = source_2_address;
                    rd_n        = destination_address;
                    busy_n      = 1'b1;
                    error_n     = 1'b0;
                    state_n     = S_LATCH;
                end
            end
            S_LATCH: begin
                if (op_type_q > OPT_I) begin
                    error_n = 1'b1;
                    state_n = S_COMMIT;
                end else begin
                    unit_a_n      = source_1_value;
                    unit_b_n      = (op_type_q == OPT_R) ? source_2_value : imm_q;
                    unit_in_stb_n = 1'b1;
                    state_n       = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (timeout) begin
                    unit_in_stb_n = 1'b0;
                    error_n       = 1'b1;
                    state_n       = S_COMMIT;
                end else if (xfer(unit_in_stb, unit_in_busy)) begin
                    unit_in_stb_n   = 1'b0;
                    unit_out_busy_n = 1'b0;
                    state_n         = S_WAIT;
                end
            end
            S_WAIT: begin
                if (timeout) begin
                    unit_out_busy_n = 1'b1;
                    error_n         = 1'b1;
                    state_n         = S_COMMIT;
                end else if (xfer(unit_out_stb, unit_out_busy)) begin
                    destination_value_n = unit_out;
                    unit_out_busy_n     = 1'b1;
                    state_n             = S_WRITE;
                end
            end
            S_WRITE: begin
                // A suppressed write to r0 is silent: no error is flagged.
                write_enable_n = !((ZERO_REG_PROTECT != 0) && (rd == '0));
                state_n        = S_COMMIT;
            end
            S_COMMIT: begin
                next_pc_n = pc_q + 1'b1;
                busy_n    = 1'b0;
                done_n    = 1'b1;
                state_n   = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // State and output registers; synchronous reset abandons any instruction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= S_IDLE;
            pc_q              <= '0;
            op_type_q         <= '0;
            imm_q             <= '0;
            rs1               <= '0;
            rs2               <= '0;
            rd                <= '0;
            destination_value <= '0;
            unit_a            <= '0;
            unit_b            <= '0;
            unit_op           <= '0;
            next_pc           <= '0;
            write_enable      <= 1'b0;
            busy              <= 1'b0;
            done              <= 1'b0;
            error             <= 1'b0;
            unit_in_stb       <= 1'b0;
            unit_out_busy     <= 1'b1;
        end else begin
            state             <= state_n;
            pc_q              <= pc_q_n;
            op_type_q         <= op_type_q_n;
            imm_q             <= imm_q_n;
            rs1               <= rs1_n;
            rs2               <= rs2_n;
            rd                <= rd_n;
            destination_value <= destination_value_n;
            unit_a            <= unit_a_n;
            unit_b            <= unit_b_n;
            unit_op           <= unit_op_n;
            next_pc           <= next_pc_n;
            write_enable      <= write_enable_n;
            busy              <= busy_n;
            done              <= done_n;
            error             <= error_n;
            unit_in_stb       <= unit_in_stb_n;
            unit_out_busy     <= unit_out_busy_n;
        end
    end

endmodule

// File: doc/fpu_op_controller.md
Name: fpu_op_controller

Overview:
Parametrised successor to the single-function multiply controller. Executes one floating-point ALU instruction (ADD/SUB/MUL/DIV), R-type or I-type, end to end:
- reads operands from the register file;
- drives an external FPU unit over a strobe/busy handshake;
- writes the result back and reports next_pc, busy, done and error to the instruction decode controller.

Sits between instruction decode, the register file and the FPU datapath.

Parameters:
- WORD_SIZE, 32, operand/result width.
- NUMBER_OF_REGISTERS, 32, register file depth; ADDR_WIDTH = $clog2(NUMBER_OF_REGISTERS).
- NUMBER_OF_PC_REGISTERS, 256, program space; PC_WIDTH = $clog2(NUMBER_OF_PC_REGISTERS).
- ZERO_REG_PROTECT, 1, when 1 a write to register 0 is suppressed.
- TIMEOUT_CYCLES, 64, watchdog limit; used only with FPU_CTRL_TIMEOUT_EN.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  instruction issue strobe from decode
- operation_type  in  2  0=R, 1=I, 2..3 illegal
- op_code  in  2  0=ADD, 1=SUB, 2=MUL, 3=DIV
- pc  in  PC_WIDTH  current PC
- source_1_address / source_2_address / destination_address  in  ADDR_WIDTH  Rs1/Rs2/Rd
- source_immediate_value  in  WORD_SIZE  I-type operand 2
- rs1, rs2, rd  out  ADDR_WIDTH  register file addresses
- source_1_value, source_2_value  in  WORD_SIZE  register file read data (combinational read)
- destination_value  out  WORD_SIZE  write data
- write_enable  out  1  register file write strobe
- next_pc  out  PC_WIDTH  PC after completion
- busy, done, error  out  1  status to decode
- unit_a, unit_b  out  WORD_SIZE  FPU operands
- unit_op  out  2  latched op_code
- unit_in_stb  out  1  operands valid
- unit_in_busy  in  1  FPU cannot accept
- unit_out  in  WORD_SIZE  FPU result
- unit_out_stb  in  1  result valid
- unit_out_busy  out  1  controller cannot accept result

Behaviour:
- Reset values:
  - state=IDLE.
  - busy, done, error, write_enable, unit_in_stb = 0; unit_out_busy=1.
  - next_pc, rs1, rs2, rd, destination_value, unit_a, unit_b, unit_op = 0.
- Reset mid-operation aborts immediately: no write, no done; any FPU transaction in flight is abandoned.
- Handshake rule (both directions): a transfer occurs on a clock edge where stb=1 and busy=0.
- State machine:
  - IDLE: when start=1, latch pc, addresses, op_code, operation_type and immediate. Drive rs1/rs2. Set busy=1, done=0, error=0. Go to LATCH. start while busy=1 is ignored.
  - LATCH:
    - If operation_type>1: error=1, go to COMMIT.
    - Otherwise latch unit_a=source_1_value and unit_b=(R ? source_2_value : immediate), then go to ISSUE.
  - ISSUE: unit_in_stb=1, held until unit_in_busy=0 is sampled. On that edge drop unit_in_stb, set unit_out_busy=0, go to WAIT.
  - WAIT: on unit_out_stb=1 (with unit_out_busy=0), capture unit_out, set unit_out_busy=1, go to WRITE.
  - WRITE:
    - write_enable=1 for exactly one cycle, with rd and destination_value.
    - Write is suppressed (write_enable stays 0) when ZERO_REG_PROTECT=1 and Rd=0; error stays 0 in that case.
    - Go to COMMIT.
  - COMMIT:
    - next_pc = latched pc+1, modulo 2^PC_WIDTH (wraps to 0).
    - busy=0; done=1 as a single-cycle pulse. Go to IDLE.
- On an illegal operation_type, next_pc is still advanced.
- Latency with a zero-wait FPU responding N cycles after acceptance: start to done = 5+N cycles.
- next_pc and error hold until the next start.
- Signed ops are the FPU's concern; the controller is width-agnostic pass-through.

Optional Feature:
FPU_CTRL_TIMEOUT_EN
- Defined:
  - A counter runs in ISSUE and WAIT and clears on entering each of them.
  - Reaching TIMEOUT_CYCLES forces: unit_in_stb=0, unit_out_busy=1, error=1, no write-back, COMMIT.
- Undefined: no counter; the controller waits indefinitely.

Decomposition:
- Shared package fpu_ctrl_pkg:
  - operation-type encodings (R, I);
  - op_code encodings (ADD, SUB, MUL, DIV);
  - state encodings;
  - the handshake-transfer helper function.
- One natural sub-module, fpu_ctrl_watchdog: the timeout counter, instantiated only under FPU_CTRL_TIMEOUT_EN.

Test Plan:
1. R-type MUL: R1=0x40000000, R2=0x40400000, Rd=3, pc=10, model FPU returns 0x40C00000 after 2 cycles -> unit_op=2, single write_enable to rd=3 with 0x40C00000, done pulse at cycle 7, next_pc=11, error=0.
2. I-type ADD, immediate 0x3F800000, unit_in_busy held high 4 cycles -> unit_in_stb stays 1 for those 4 cycles, unit_b=immediate, write occurs once.
3. operation_type=3 -> no unit_in_stb, no write, error=1, done pulse, next_pc=pc+1.
4. pc=255 (PC_WIDTH=8), Rd=0, ZERO_REG_PROTECT=1 -> next_pc=0, write_enable never asserted, done=1.
5. rst asserted during WAIT -> all outputs return to reset values next cycle; a subsequent instruction completes normally. start pulsed during busy -> ignored.
6. With FPU_CTRL_TIMEOUT_EN and TIMEOUT_CYCLES=8, FPU never strobes -> error=1 and done after 8 WAIT cycles, no write.
